// File: rtl/pulse_scheduler_pkg.sv
// Shared types and constants for the pulse scheduler and related shared-output arbiters.
// Holds the FSM state encoding and the trigger-edge selection codes.
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/pulse_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly after
// the last-served index, wrapping around, as one-hot, index and valid.
module pulse_rr_pick
    import pulse_scheduler_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    logic [IDXW-1:0] cand_s;
    logic            found_s;

    // Scan from last+1 upward with wrap; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s = IDXW'((int'(last_i) + i) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                valid_o        = 1'b1;
                idx_o          = cand_s;
                gnt_o[cand_s]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one timed pulse output among NUM_REQ requesters: edge triggers queue
// one-shot pulses that are served round-robin with a fixed idle gap between them.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LEN_WIDTH = 16,
    parameter int GAP       = 2,
    parameter int EDGE      = 0,
    parameter int RETRIGGER = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             din,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   pulse_len,
    output logic                           dout,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [NUM_REQ-1:0]             pending
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAPW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     din_prev_q;
    logic [NUM_REQ-1:0]     pending_q, pending_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [LEN_WIDTH-1:0]   counter_q, counter_d;
    logic [GAPW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     trig_s;
    logic [NUM_REQ-1:0]     set_s;
    logic [NUM_REQ-1:0]     clr_s;
    logic [NUM_REQ-1:0]     retrig_mask_s;
    logic [NUM_REQ-1:0]     pick_gnt_s;
    logic [IDXW-1:0]        pick_idx_s;
    logic                   pick_valid_s;
    logic                   owner_trig_s;
    logic [LEN_WIDTH-1:0]   pick_len_s;
    logic [LEN_WIDTH-1:0]   owner_len_s;
    logic [LEN_WIDTH-1:0]   len_arr_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr_s[g] = pulse_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    assign pick_len_s   = len_arr_s[pick_idx_s];
    assign owner_len_s  = len_arr_s[rr_ptr_q];
    assign owner_trig_s = |(trig_s & grant_q);

    pulse_rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (pending_q),
        .last_i  (rr_ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Trigger vector from the configured edge polarity.
    always_comb begin
        case (EDGE)
            EDGE_RISE: trig_s = din & ~din_prev_q;
            EDGE_FALL: trig_s = ~din & din_prev_q;
            EDGE_BOTH: trig_s = din ^ din_prev_q;
            default:   trig_s = din & ~din_prev_q;
        endcase
    end

    // Next-state, counter, grant and pending update.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        gap_cnt_d     = gap_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        dout_d        = dout_q;
        clr_s         = '0;
        retrig_mask_s = '0;
        case (state_q)
            ST_IDLE: begin
                dout_d  = 1'b0;
                grant_d = '0;
                if (pick_valid_s) begin
                    clr_s     = pick_gnt_s;
                    counter_d = pick_len_s;
                    rr_ptr_d  = pick_idx_s;
                    if (pick_len_s == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PULSE;
                        dout_d  = 1'b1;
                        grant_d = pick_gnt_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                // A retrigger on the owner reloads instead of queueing, even on the last cycle.
                if ((RETRIGGER != 0) && owner_trig_s) begin
                    retrig_mask_s = grant_q;
                    counter_d     = owner_len_s;
                end else if (counter_q == LEN_WIDTH'(1)) begin
                    dout_d  = 1'b0;
                    grant_d = '0;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAPW'(GAP);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    counter_d = counter_q - LEN_WIDTH'(1);
                end
            end
            ST_GAP: begin
                dout_d  = 1'b0;
                grant_d = '0;
                if (gap_cnt_q == GAPW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAPW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
                grant_d = '0;
            end
        endcase
        // A grant's clear overrides a same-cycle trigger on that channel.
        set_s     = trig_s & ~retrig_mask_s;
        pending_d = (pending_q | set_s) & ~clr_s;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            din_prev_q <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            counter_q  <= '0;
            gap_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_prev_q <= din;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            counter_q  <= counter_d;
            gap_cnt_q  <= gap_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
        end
    end

    assign dout    = dout_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed self-checking bench for pulse_scheduler; a RETRIGGER=0 and a RETRIGGER=1
// instance share stimulus so the retrigger behaviours can be compared side by side.
module tb_pulse_scheduler;

    localparam int N  = 4;
    localparam int LW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      din;
    logic [N*LW-1:0]   pulse_len;
    logic              dout0, busy0, dout1, busy1;
    logic [N-1:0]      grant0, pending0, grant1, pending1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pulse_scheduler #(.NUM_REQ(N), .LEN_WIDTH(LW), .GAP(2), .EDGE(0), .RETRIGGER(0)) dut (
        .clk(clk), .rst(rst), .din(din), .pulse_len(pulse_len),
        .dout(dout0), .grant(grant0), .busy(busy0), .pending(pending0)
    );

    pulse_scheduler #(.NUM_REQ(N), .LEN_WIDTH(LW), .GAP(2), .EDGE(0), .RETRIGGER(1)) dut_rt (
        .clk(clk), .rst(rst), .din(din), .pulse_len(pulse_len),
        .dout(dout1), .grant(grant1), .busy(busy1), .pending(pending1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int ch, input int len);
        pulse_len[ch*LW +: LW] = 16'(len);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; pulse_len = '0;
        repeat (3) tick();
        tests_run++;
        if ({dout0, busy0, grant0, pending0} !== 10'b0) begin
            tests_failed++; $display("FAIL reset_hold got=%b exp=%b", {dout0, busy0, grant0, pending0}, 10'b0);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({dout0, busy0, grant0, pending0, dout1, busy1, grant1, pending1} !== 20'b0) begin
            tests_failed++; $display("FAIL reset_release got=%b exp=%b", {dout0, busy0, grant0, pending0, dout1, busy1, grant1, pending1}, 20'b0);
        end
    endtask

    task automatic test_single();
        logic       exp_d, exp_b;
        logic [3:0] exp_g;
        set_len(0, 5);
        din[0] = 1'b1;
        tick();
        tests_run++;
        if (pending0 !== 4'b0001 || dout0 !== 1'b0) begin
            tests_failed++; $display("FAIL single_pending got=%b/%b exp=0001/0", pending0, dout0);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k <= 5);
            exp_g = (k <= 5) ? 4'b0001 : 4'b0000;
            exp_b = (k <= 7);
            tests_run++;
            if (dout0 !== exp_d || grant0 !== exp_g || busy0 !== exp_b) begin
                tests_failed++; $display("FAIL single_pulse k=%0d got d=%b g=%b b=%b exp d=%b g=%b b=%b", k, dout0, grant0, busy0, exp_d, exp_g, exp_b);
            end
            if (k == 1) din[0] = 1'b0;
        end
    endtask

    task automatic test_two_channels();
        logic       exp_d;
        logic [3:0] exp_g;
        set_len(1, 3); set_len(3, 4);
        din[1] = 1'b1; din[3] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            exp_d = (k >= 1 && k <= 3) || (k >= 7 && k <= 10);
            exp_g = (k >= 1 && k <= 3) ? 4'b0010 : ((k >= 7 && k <= 10) ? 4'b1000 : 4'b0000);
            tests_run++;
            if (dout0 !== exp_d || grant0 !== exp_g) begin
                tests_failed++; $display("FAIL two_ch k=%0d got d=%b g=%b exp d=%b g=%b", k, dout0, grant0, exp_d, exp_g);
            end
            if (k == 0 || k == 1 || k == 7) begin
                tests_run++;
                if (pending0 !== ((k == 0) ? 4'b1010 : ((k == 1) ? 4'b1000 : 4'b0000))) begin
                    tests_failed++; $display("FAIL two_ch_pending k=%0d got=%b", k, pending0);
                end
            end
            if (k == 1) begin din[1] = 1'b0; din[3] = 1'b0; end
        end
        repeat (3) tick();
    endtask

    task automatic test_zero_len();
        set_len(0, 0); set_len(1, 3);
        din[0] = 1'b1; din[1] = 1'b1;
        tick();
        tests_run++;
        if (pending0 !== 4'b0011) begin
            tests_failed++; $display("FAIL zero_pending0 got=%b exp=0011", pending0);
        end
        tick();
        din[0] = 1'b0; din[1] = 1'b0;
        tests_run++;
        if (pending0 !== 4'b0010 || dout0 !== 1'b0 || grant0 !== 4'b0000 || busy0 !== 1'b0) begin
            tests_failed++; $display("FAIL zero_drop got p=%b d=%b g=%b b=%b exp p=0010 d=0 g=0000 b=0", pending0, dout0, grant0, busy0);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            tests_run++;
            if (dout0 !== (k <= 4) || grant0 !== ((k <= 4) ? 4'b0010 : 4'b0000)) begin
                tests_failed++; $display("FAIL zero_next k=%0d got d=%b g=%b", k, dout0, grant0);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_collision();
        set_len(0, 2); set_len(2, 2);
        din[0] = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            tick();
            if (k == 1) begin
                tests_run++;
                if (grant0 !== 4'b0001 || dout0 !== 1'b1) begin
                    tests_failed++; $display("FAIL coll_first got g=%b d=%b exp g=0001 d=1", grant0, dout0);
                end
            end
            if (k == 2) begin
                tests_run++;
                if (pending0 !== 4'b0100) begin
                    tests_failed++; $display("FAIL coll_queue got=%b exp=0100", pending0);
                end
            end
            if (k == 6) begin
                tests_run++;
                if (grant0 !== 4'b0100 || dout0 !== 1'b1 || pending0 !== 4'b0000) begin
                    tests_failed++; $display("FAIL coll_grant got g=%b d=%b p=%b exp g=0100 d=1 p=0000", grant0, dout0, pending0);
                end
            end
            if (k >= 11) begin
                tests_run++;
                if (dout0 !== 1'b0 || pending0 !== 4'b0000 || busy0 !== 1'b0) begin
                    tests_failed++; $display("FAIL coll_lost k=%0d got d=%b p=%b b=%b exp d=0 p=0000 b=0", k, dout0, pending0, busy0);
                end
            end
            if (k == 0) din[0] = 1'b0;
            if (k == 1) din[2] = 1'b1;
            if (k == 2) din[2] = 1'b0;
            if (k == 5) din[2] = 1'b1;
            if (k == 6) din[2] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int         exp_ch;
        int         grants;
        logic [3:0] prev_g;
        logic [3:0] exp_g;
        bit         drained;
        for (int c = 0; c < N; c++) set_len(c, 2);
        exp_ch = 3;
        grants = 0;
        prev_g = 4'b0000;
        din = 4'b1111;
        for (int c = 0; c < 200; c++) begin
            tick();
            din = ~din;
            if (grant0 !== 4'b0000 && prev_g === 4'b0000) begin
                exp_g = 4'b0001 << exp_ch;
                tests_run++;
                if (grant0 !== exp_g) begin
                    tests_failed++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, grant0, exp_g);
                end
                exp_ch = (exp_ch + 1) % N;
                grants++;
            end
            tests_run++;
            if (dout0 !== (grant0 !== 4'b0000)) begin
                tests_failed++; $display("FAIL rr_dout c=%0d got d=%b g=%b b=%b", c, dout0, grant0, busy0);
            end
            prev_g = grant0;
        end
        tests_run++;
        if (grants !== 40) begin
            tests_failed++; $display("FAIL rr_count got=%0d exp=40", grants);
        end
        din = '0;
        drained = 1'b0;
        for (int c = 0; c < 60 && !drained; c++) begin
            tick();
            if (busy0 === 1'b0 && pending0 === 4'b0000) drained = 1'b1;
        end
        tests_run++;
        if (!drained) begin
            tests_failed++; $display("FAIL rr_drain got busy=%b pending=%b exp idle", busy0, pending0);
        end
    endtask

    task automatic test_retrigger();
        logic e0, e1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        set_len(2, 10);
        din[2] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            tick();
            e0 = (k >= 1 && k <= 10) || (k >= 14 && k <= 23);
            e1 = (k >= 1 && k <= 16);
            tests_run++;
            if (dout0 !== e0) begin
                tests_failed++; $display("FAIL retrig0_dout k=%0d got=%b exp=%b", k, dout0, e0);
            end
            tests_run++;
            if (dout1 !== e1) begin
                tests_failed++; $display("FAIL retrig1_dout k=%0d got=%b exp=%b", k, dout1, e1);
            end
            if (k == 7 || k == 8) begin
                tests_run++;
                if (pending0 !== 4'b0100 || pending1 !== 4'b0000) begin
                    tests_failed++; $display("FAIL retrig_pending k=%0d got p0=%b p1=%b exp p0=0100 p1=0000", k, pending0, pending1);
                end
            end
            if (k == 1) din[2] = 1'b0;
            if (k == 6) din[2] = 1'b1;
            if (k == 7) din[2] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        set_len(0, 8); set_len(1, 3);
        din[0] = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k == 0) begin din[0] = 1'b0; din[1] = 1'b1; end
        end
        tests_run++;
        if (dout0 !== 1'b1 || pending0 !== 4'b0010) begin
            tests_failed++; $display("FAIL arst_pre got d=%b p=%b exp d=1 p=0010", dout0, pending0);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({dout0, busy0, grant0, pending0, dout1, busy1, grant1, pending1} !== 20'b0) begin
            tests_failed++; $display("FAIL arst_immediate got=%b exp=%b", {dout0, busy0, grant0, pending0, dout1, busy1, grant1, pending1}, 20'b0);
        end
        din = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (dout0 !== 1'b0 || busy0 !== 1'b0 || pending0 !== 4'b0000) begin
                tests_failed++; $display("FAIL arst_no_resume k=%0d got d=%b b=%b p=%b exp 0", k, dout0, busy0, pending0);
            end
        end
        din[0] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            tick();
            tests_run++;
            if (dout0 !== (k >= 1 && k <= 8)) begin
                tests_failed++; $display("FAIL arst_new_pulse k=%0d got=%b exp=%b", k, dout0, (k >= 1 && k <= 8));
            end
            if (k == 1) begin
                din[0] = 1'b0;
                tests_run++;
                if (grant0 !== 4'b0001) begin
                    tests_failed++; $display("FAIL arst_new_grant got=%b exp=0001", grant0);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_two_channels();
        test_zero_len();
        test_collision();
        test_round_robin();
        test_retrigger();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Shares one timed pulse output between NUM_REQ requesters. Each requester's trigger edge queues a one-shot pulse of that requester's programmed length. Pending requests are served round-robin, with a programmable idle gap between pulses. The block sits in front of a single physical output (solenoid, strobe, laser gate), so no requester can stretch or overlap another's pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LEN_WIDTH, 16, width of each pulse-length field, in clk cycles
GAP, 2, idle cycles forced between consecutive pulses (0 allowed)
EDGE, 0, trigger edge: 0 rising, 1 falling, 2 both
RETRIGGER, 0, 1 = a trigger from the channel currently in service restarts its pulse

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
din  in  NUM_REQ  per-requester trigger inputs; already synchronous to clk
pulse_len  in  NUM_REQ*LEN_WIDTH  per-requester length; channel i occupies bits [i*LEN_WIDTH +: LEN_WIDTH]
dout  out  1  shared pulse output, registered
grant  out  NUM_REQ  one-hot owner of the current pulse; all zero outside PULSE
busy  out  1  high in PULSE and GAP
pending  out  NUM_REQ  queued, not-yet-served requests

Behaviour:
- Reset (async, active-high) clears the following to 0 immediately, mid-pulse included: dout, grant, busy, pending, din_prev, counter and rr pointer. The FSM goes to IDLE. No partial pulse resumes after reset.
- Edge detect: din_prev is registered. The trigger vector is selected by EDGE: rising = din & ~din_prev, falling = ~din & din_prev, both = din ^ din_prev.
- A trigger on channel i sets pending[i]. Repeated triggers while pending[i]=1 collapse into one request.
- FSM has three states: IDLE, PULSE, GAP.
- IDLE, pending != 0:
  - Pick the first set pending bit, searching from rr_ptr+1 upward with wrap-around. Call it channel k.
  - Clear pending[k], load counter = pulse_len[k] and set rr_ptr = k.
  - If pulse_len[k] == 0: drop the request (no pulse) and stay in IDLE.
  - Otherwise go to PULSE, setting dout=1 and grant=1<<k.
- PULSE: counter decrements each cycle, so dout is high for exactly pulse_len[k] cycles.
  - At counter==1, leave PULSE: go to GAP if GAP>0, else IDLE.
  - dout and grant drop on the same edge.
- GAP: hold dout=0 for exactly GAP cycles, then go to IDLE.
- Latency from trigger to dout high, with the block idle:
  - din changes before edge n, so pending is set at edge n.
  - dout rises at edge n+1 (2 cycles from the din edge).
- Back-to-back service: the next grant is issued in the IDLE cycle after GAP, so consecutive pulses are separated by GAP+1 low cycles.
- pulse_len is sampled only at grant. Changing it mid-pulse has no effect, except on a RETRIGGER reload.
- Trigger on the in-service channel k during PULSE:
  - RETRIGGER=1: counter reloads with the current pulse_len[k] and pending[k] stays clear.
  - RETRIGGER=0: pending[k] is set and served in turn.
- A trigger on the owner during GAP always sets pending.
- Simultaneous trigger and grant on the same channel in IDLE: the grant's clear wins. The new edge is lost only if it coincides with that grant cycle; the bench checks this rule.
- Arithmetic: counter is LEN_WIDTH bits. Max pulse = 2^LEN_WIDTH-1 cycles. The counter never wraps because 0 is rejected at grant.

Decomposition:
- Shared package: state enum (IDLE, PULSE, GAP) and EDGE encoding constants (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2).
- One sub-module, pulse_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, index, valid.
  - Reused by other shared-output arbiters.

Test Plan:
- Reset then single rising edge on din[0], pulse_len[0]=5, GAP=2 -> dout high 2 cycles after the edge, high exactly 5 cycles, grant=4'b0001 during the pulse, busy low 2 cycles after dout falls.
- din[1] and din[3] rise in the same cycle, lengths 3 and 4 -> channel 1 pulse (3 cycles), then 3 low cycles, then channel 3 pulse (4 cycles); pending shows 4'b1010 then 4'b1000.
- All four channels trigger repeatedly for 200 cycles, lengths 2 -> grants rotate 0,1,2,3,0...; no channel is served twice before another pending one; dout never high during GAP.
- RETRIGGER=1, channel 2 length 10, second edge 6 cycles into the pulse -> dout high 16 cycles total, pending[2] stays 0. With RETRIGGER=0, same stimulus -> 10-cycle pulse, gap, a second 10-cycle pulse.
- pulse_len[0]=0 with a trigger on channel 0 -> no dout activity, pending[0] clears; a channel 1 trigger in the same cycle is served next.
- rst asserted 3 cycles into an 8-cycle pulse, released 2 cycles later -> dout, grant, busy and pending go 0 immediately without waiting for a clk edge; no pulse resumes; a new trigger after release gives a normal pulse.
